// File: rtl/median_pkg.sv
// Shared constants and state type for the median filter feeder.
package median_pkg;

    // Pixels per median window (3x3 neighbourhood).
    localparam int NPIX        = 9;
    // Default number of WAIT cycles tolerated without a result strobe.
    localparam int TIMEOUT_DEF = 64;
    // Pixel width on both the upstream and filter side.
    localparam int PIX_W       = 8;
    // Width of the window pixel counter and send index (0..NPIX-1).
    localparam int CNT_W       = $clog2(NPIX);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SEND,
        ST_WAIT,
        ST_OUT
    } state_t;

endpackage

// File: rtl/median_feeder.sv
// Median feeder: gathers a 9-pixel window from upstream, streams it to the
// median filter as a contiguous burst, waits (bounded) for the result strobe
// and presents the captured median downstream with a valid/ready handshake.
module median_feeder
    import median_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             IN_VALID,
    input  logic [PIX_W-1:0] IN_DATA,
    output logic             IN_READY,
    output logic             DSI,
    output logic [PIX_W-1:0] DI,
    input  logic             DSO,
    input  logic [PIX_W-1:0] DO,
    output logic             OUT_VALID,
    output logic [PIX_W-1:0] OUT_DATA,
    input  logic             OUT_READY,
    output logic             BUSY,
    output logic             ERR
);

    // Timer holds 0..TIMEOUT-1, so it never wraps.
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   idx_next;
    logic [TMR_W-1:0]   timer;
    logic [PIX_W-1:0]   pix_buf [NPIX];
    logic               accept;
    logic               last_pix;
    logic               last_send;
    logic               timer_done;

    assign accept     = (state == ST_COLLECT) && IN_VALID;
    assign last_pix   = (cnt == CNT_W'(NPIX - 1));
    assign last_send  = (idx == CNT_W'(NPIX - 1));
    assign idx_next   = idx + 1'b1;
    assign timer_done = (timer == TMR_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block evaluation order.
        if (!nRST) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_next = state;
        IN_READY   = 1'b0;
        BUSY       = 1'b0;
        case (state)
            ST_COLLECT: begin
                IN_READY = 1'b1;
                if (IN_VALID && last_pix) state_next = ST_SEND;
            end
            ST_SEND: begin
                BUSY = 1'b1;
                if (last_send) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                BUSY = 1'b1;
                // A result strobe on the final timeout cycle still wins.
                if (DSO)             state_next = ST_OUT;
                else if (timer_done) state_next = ST_COLLECT;
            end
            ST_OUT: begin
                if (OUT_READY) state_next = ST_COLLECT;
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // Window storage: written only on accepted pixels.
    always_ff @(posedge CLK) begin
        // NOTE: the pixel buffer is deliberately not reset; every entry is
        // rewritten before it is read, and a reset would only cost a mux per bit.
        if (accept) pix_buf[cnt] <= IN_DATA;
    end

    // Counters, filter strobe/data, result capture and sticky error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt       <= '0;
            idx       <= '0;
            timer     <= '0;
            DSI       <= 1'b0;
            DI        <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            ERR       <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (IN_VALID) begin
                        if (last_pix) begin
                            // Launch the burst so DSI is high on the first SEND cycle.
                            cnt <= '0;
                            idx <= '0;
                            DSI <= 1'b1;
                            DI  <= pix_buf[0];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (last_send) begin
                        idx   <= '0;
                        timer <= '0;
                        DSI   <= 1'b0;
                        DI    <= '0;
                    end else begin
                        idx <= idx_next;
                        DI  <= pix_buf[idx_next];
                    end
                end
                ST_WAIT: begin
                    if (DSO) begin
                        OUT_DATA  <= DO;
                        OUT_VALID <= 1'b1;
                    end else if (timer_done) begin
                        // Abandon the window; the filter never answered.
                        ERR   <= 1'b1;
                        timer <= '0;
                        cnt   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_median_feeder.sv
// Bench for median_feeder: a behavioural median filter answers each burst,
// a manual strobe override covers ignored/late DSO cases, and a queue-based
// model supplies the expected pixel stream and median for every window.
module tb_median_feeder;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       dsi;
    logic [7:0] di;
    logic       dso;
    logic [7:0] do_val;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       err;

    // Responder (filter model) outputs and bench override.
    logic       resp_dso = 1'b0;
    logic [7:0] resp_do  = 8'h00;
    logic       man_dso;
    logic [7:0] man_do;
    bit         resp_mute;

    assign dso    = resp_dso | man_dso;
    assign do_val = man_dso ? man_do : resp_do;

    always #5 clk = ~clk;

    median_feeder #(.TIMEOUT(TO)) dut (
        .CLK       (clk),
        .nRST      (rst_n),
        .IN_VALID  (in_valid),
        .IN_DATA   (in_data),
        .IN_READY  (in_ready),
        .DSI       (dsi),
        .DI        (di),
        .DSO       (dso),
        .DO        (do_val),
        .OUT_VALID (out_valid),
        .OUT_DATA  (out_data),
        .OUT_READY (out_ready),
        .BUSY      (busy),
        .ERR       (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int median_q(input int w[$]);
        int s[$];
        s = w;
        s.sort();
        return s[s.size() / 2];
    endfunction

    function automatic int median_of(input logic [8:0][7:0] p);
        int s[$];
        for (int i = 0; i < 9; i++) s.push_back(int'(p[i]));
        return median_q(s);
    endfunction

    function automatic logic [8:0][7:0] mk(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        logic [8:0][7:0] p;
        p[0] = 8'(a0); p[1] = 8'(a1); p[2] = 8'(a2);
        p[3] = 8'(a3); p[4] = 8'(a4); p[5] = 8'(a5);
        p[6] = 8'(a6); p[7] = 8'(a7); p[8] = 8'(a8);
        return p;
    endfunction

    // Behavioural median filter: collects 9 strobed pixels, answers 3 cycles later.
    int win[$];
    int lat = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win.delete();
            lat = 0;
            resp_dso <= 1'b0;
            resp_do  <= 8'h00;
        end else begin
            resp_dso <= 1'b0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    resp_dso <= 1'b1;
                    resp_do  <= 8'(median_q(win));
                    win.delete();
                end
            end
            if (dsi) begin
                win.push_back(int'(di));
                if (win.size() == 9) begin
                    if (resp_mute) win.delete();
                    else           lat = 3;
                end
            end
        end
    end

    // Monitor: records the filter-side pixel stream and DSI run lengths.
    logic [7:0] di_seen[$];
    int         runs[$];
    int         cur_run  = 0;
    int         idle_bad = 0;
    always @(negedge clk) begin
        if (dsi === 1'b1) begin
            di_seen.push_back(di);
            cur_run++;
        end else begin
            if (cur_run > 0) runs.push_back(cur_run);
            cur_run = 0;
            if (di !== 8'h00) idle_bad++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " dsi"},       72'(dsi),       72'(0));
        check({tag, " di"},        72'(di),        72'(0));
        check({tag, " out_valid"}, 72'(out_valid), 72'(0));
        check({tag, " out_data"},  72'(out_data),  72'(0));
        check({tag, " err"},       72'(err),       72'(0));
        check({tag, " busy"},      72'(busy),      72'(0));
        check({tag, " in_ready"},  72'(in_ready),  72'(1));
    endtask

    // Offer 9 pixels; gap>0 inserts 1..gap idle cycles (with junk data) before each.
    task automatic feed(input logic [8:0][7:0] pix, input int gap);
        int w;
        for (int i = 0; i < 9; i++) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, gap)) begin
                    in_data = 8'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = pix[i];
            w = 0;
            while (in_ready !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                check("feed in_ready wait", 72'(in_ready), 72'(1));
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_dsi_low(input string tag);
        int w = 0;
        while (dsi !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, " dsi drop"}, 72'(dsi), 72'(0));
    endtask

    // One full window: feed, wait for the result, hold off, then hand it off.
    task automatic run_window(input string tag, input logic [8:0][7:0] pix,
                              input int gap, input int hold, input logic [7:0] exp_med);
        logic [8:0][7:0] seen;
        bit              stable;
        int              w;
        di_seen.delete();
        runs.delete();
        feed(pix, gap);
        w = 0;
        while (out_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({tag, " out_valid"}, 72'(out_valid), 72'(1));
        check({tag, " out_data"},  72'(out_data),  72'(exp_med));
        check({tag, " di count"},  72'(di_seen.size()), 72'(9));
        seen = '0;
        for (int i = 0; i < 9 && i < di_seen.size(); i++) seen[i] = di_seen[i];
        check({tag, " di order"},  72'(seen), 72'(pix));
        check({tag, " dsi bursts"}, 72'(runs.size()), 72'(1));
        check({tag, " dsi run len"}, 72'((runs.size() > 0) ? runs[0] : 0), 72'(9));
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!(out_valid === 1'b1 && out_data === exp_med &&
                      in_ready === 1'b0 && busy === 1'b0)) stable = 1'b0;
            end
            check({tag, " hold stable"}, 72'(stable), 72'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid clr"}, 72'(out_valid), 72'(0));
        check({tag, " back to collect"}, 72'(in_ready), 72'(1));
    endtask

    typedef struct {
        logic [8:0][7:0] pix;
        int              gap;
        int              hold;
        logic [7:0]      med;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [8:0][7:0] rp;
        logic [7:0]      last_med;

        vecs[0] = '{pix: mk(10,90,30,70,50,20,80,40,60), gap: 0, hold: 0, med: 8'd50};
        vecs[1] = '{pix: mk(10,90,30,70,50,20,80,40,60), gap: 3, hold: 0, med: 8'd50};
        vecs[2] = '{pix: mk(10,90,30,70,50,20,80,40,60), gap: 0, hold: 5, med: 8'd50};
        vecs[3] = '{pix: mk(0,0,0,0,0,0,0,0,0),           gap: 1, hold: 1, med: 8'd0};
        vecs[4] = '{pix: mk(255,255,255,255,255,255,255,255,255), gap: 0, hold: 2, med: 8'd255};
        vecs[5] = '{pix: mk(9,8,7,6,5,4,3,2,1),            gap: 2, hold: 2, med: 8'd5};
        vecs[6] = '{pix: mk(200,1,255,0,128,127,129,3,250), gap: 1, hold: 3, med: 8'd128};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        man_dso   = 1'b0;
        man_do    = 8'h00;
        resp_mute = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 7; v++)
            run_window($sformatf("vec%0d", v), vecs[v].pix, vecs[v].gap, vecs[v].hold, vecs[v].med);
        last_med = vecs[6].med;

        // Stray result strobe while collecting must be ignored.
        man_dso = 1'b1;
        man_do  = 8'hAA;
        @(negedge clk);
        man_dso = 1'b0;
        check("stray dso out_data",  72'(out_data),  72'(last_med));
        check("stray dso out_valid", 72'(out_valid), 72'(0));
        check("stray dso in_ready",  72'(in_ready),  72'(1));
        run_window("after stray", vecs[0].pix, 1, 0, 8'd50);

        // Randomized windows against the queue model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) rp[i] = 8'($urandom_range(0, 255));
            run_window($sformatf("rand%0d", r), rp, $urandom_range(0, 3),
                       $urandom_range(0, 4), 8'(median_of(rp)));
        end

        // Result strobe on the last timeout cycle wins over the abort.
        resp_mute = 1'b1;
        feed(vecs[5].pix, 0);
        wait_dsi_low("edge");
        repeat (TO - 1) @(negedge clk);
        check("edge busy before strobe", 72'(busy), 72'(1));
        man_dso = 1'b1;
        man_do  = 8'h5C;
        @(negedge clk);
        man_dso = 1'b0;
        check("edge out_valid", 72'(out_valid), 72'(1));
        check("edge out_data",  72'(out_data),  72'(8'h5C));
        check("edge err",       72'(err),       72'(0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Silent filter: abort exactly TO cycles after WAIT entry.
        feed(vecs[6].pix, 0);
        wait_dsi_low("timeout");
        check("timeout busy at entry", 72'(busy), 72'(1));
        repeat (TO - 1) @(negedge clk);
        check("timeout err early", 72'(err),  72'(0));
        check("timeout busy late", 72'(busy), 72'(1));
        @(negedge clk);
        check("timeout err",       72'(err),       72'(1));
        check("timeout in_ready",  72'(in_ready),  72'(1));
        check("timeout busy",      72'(busy),      72'(0));
        check("timeout out_valid", 72'(out_valid), 72'(0));
        resp_mute = 1'b0;
        run_window("after timeout", vecs[5].pix, 0, 1, 8'd5);
        check("err sticky", 72'(err), 72'(1));

        // Reset on the 4th SEND cycle.
        feed(vecs[6].pix, 0);
        repeat (3) @(negedge clk);
        check("mid send dsi", 72'(dsi), 72'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid send reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_window("after reset", vecs[0].pix, 2, 1, 8'd50);

        check("di zero while dsi low", 72'(idle_bad), 72'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/median_feeder.md
MEDIAN_FEEDER -- requirements
Module: median_feeder

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum cycles in WAIT without DSO before abort.
REQ-002 CLK  input  1  system clock, all state changes on rising edge.
REQ-003 nRST  input  1  asynchronous, active-low reset.
REQ-004 IN_VALID  input  1  upstream pixel valid.
REQ-005 IN_DATA  input  8  upstream pixel value.
REQ-006 IN_READY  output  1  feeder accepts a pixel this cycle.
REQ-007 DSI  output  1  pixel strobe to the median filter, high for each of the 9 window pixels.
REQ-008 DI  output  8  pixel to the median filter, valid while DSI=1.
REQ-009 DSO  input  1  one-cycle result strobe from the median filter.
REQ-010 DO  input  8  median result from the filter, valid while DSO=1.
REQ-011 OUT_VALID  output  1  result available downstream.
REQ-012 OUT_DATA  output  8  captured median.
REQ-013 OUT_READY  input  1  downstream accepts the result.
REQ-014 BUSY  output  1  high in SEND or WAIT.
REQ-015 ERR  output  1  sticky timeout flag.

Function
REQ-016 The block SHALL implement states COLLECT, SEND, WAIT and OUT.
REQ-017 COLLECT: IN_READY=1; each cycle with IN_VALID=1 stores IN_DATA in buf[cnt] and increments cnt (0..8).
REQ-018 The cycle after the 9th accept, the state SHALL be SEND with cnt=0; IN_READY=0 outside COLLECT.
REQ-019 SEND: DSI=1 and DI=buf[idx] for exactly 9 consecutive cycles, idx 0..8, with no gaps.
REQ-020 DSI and DI SHALL be driven from flops; DI SHALL be 0 whenever DSI=0.
REQ-021 After the 9th SEND cycle the state SHALL be WAIT with DSI=0 and the timeout counter cleared.
REQ-022 WAIT: DSO=1 SHALL capture DO into OUT_DATA, set OUT_VALID=1 next cycle and enter OUT.
REQ-023 WAIT: the counter SHALL increment each cycle without DSO, and on reaching TIMEOUT SHALL set ERR, discard the window and enter COLLECT with cnt=0.
REQ-024 DSO in any state other than WAIT SHALL be ignored, with no change to OUT_DATA.
REQ-025 OUT: OUT_VALID and OUT_DATA SHALL hold stable until OUT_VALID&&OUT_READY.
REQ-026 On that transfer, OUT_VALID SHALL clear next cycle and the state SHALL enter COLLECT with cnt=0.
REQ-027 DSO in the same cycle as the TIMEOUT boundary SHALL win: the result is captured and ERR is not set.
REQ-028 ERR SHALL be sticky and clear only on reset.
REQ-029 Counter widths SHALL be sized from the shared constants, with no wrap-around in normal operation.

Reset
REQ-030 nRST low SHALL force the state to COLLECT, with cnt, idx and timer at 0.
REQ-031 Output reset values: DSI=0, DI=0, OUT_VALID=0, OUT_DATA=0, ERR=0, BUSY=0, IN_READY=1.
REQ-032 Reset mid-SEND or mid-WAIT SHALL drop DSI the same instant and discard the partial window.
REQ-033 buf contents need no reset.

Structure
REQ-034 Shared package median_pkg SHALL hold constant NPIX=9, the default TIMEOUT value, and the state enum type.
REQ-035 The block SHALL be a single module with no sub-module.
REQ-036 The bench SHALL pair the block with the median filter as responder, plus a behavioural responder for fault cases.

Verification
REQ-037 Pixels 10,90,30,70,50,20,80,40,60 with IN_VALID always 1 -> DSI high 9 cycles, DI in the same order, then OUT_DATA=50, OUT_VALID=1.
REQ-038 Same pixels with IN_VALID gaps of 1-3 cycles -> 9 accepts, SEND still 9 contiguous DSI cycles, OUT_DATA=50.
REQ-039 OUT_READY held 0 for 5 cycles in OUT -> OUT_VALID/OUT_DATA stable, IN_READY=0, then COLLECT after the handshake.
REQ-040 Responder never asserts DSO -> ERR=1 exactly 64 cycles after WAIT entry, state COLLECT, OUT_VALID stays 0.
REQ-041 nRST pulsed low on the 4th SEND cycle -> DSI=0 immediately, all outputs at reset values, next window processed correctly.
REQ-042 DSO=1 with DO=0xAA during COLLECT -> ignored; OUT_DATA unchanged and the subsequent window result is correct.
